// File: rtl/piece_cell_gen.sv
// Falling-piece cell resolver: maps (piece, x, y, rot) to four board indices,
// checks board edges, then probes the occupancy RAM for a collision.
module piece_cell_gen #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int XW      = 4,
  parameter int YW      = 5,
  parameter int IDX_W   = 8,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_piece,
  input  logic [XW-1:0]      req_x,
  input  logic [YW-1:0]      req_y,
  input  logic [1:0]         req_rot,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_addr,
  input  logic               rd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [4*IDX_W-1:0] rsp_cells,
  output logic [2:0]         rsp_width,
  output logic [2:0]         rsp_height,
  output logic               rsp_oob,
  output logic               rsp_hit
);

  localparam int CW = IDX_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_PROBE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         piece_q, piece_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [1:0]         rot_q, rot_d;
  logic               req_ready_q, req_ready_d;
  logic               rd_en_q, rd_en_d;
  logic [IDX_W-1:0]   rd_addr_q, rd_addr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [4*IDX_W-1:0] cells_q, cells_d;
  logic [2:0]         w_q, w_d, h_q, h_d;
  logic               oob_q, oob_d, hit_q, hit_d;
  logic [2:0]         iss_q, iss_d;
  logic [1:0]         ret_q, ret_d;
  logic [RD_LAT-1:0]  pipe_q, pipe_d;

  logic [15:0]        shp;
  logic [2:0]         w_c, h_c;
  logic [4*IDX_W-1:0] cells_c;
  logic               oob_c;
  logic               tap;

  // Cell k packs {dy, dx} at bits [4k +: 4].
  function automatic logic [15:0] pk(input int x0, input int y0, input int x1, input int y1,
                                     input int x2, input int y2, input int x3, input int y3);
    return {2'(y3), 2'(x3), 2'(y2), 2'(x2), 2'(y1), 2'(x1), 2'(y0), 2'(x0)};
  endfunction

  always_comb begin
    shp = '0;
    w_c = 3'd0;
    h_c = 3'd0;
    case (piece_q)
      3'd1: if (!rot_q[0]) begin shp = pk(0,0, 1,0, 2,0, 3,0); w_c = 3'd4; h_c = 3'd1; end
            else           begin shp = pk(0,0, 0,1, 0,2, 0,3); w_c = 3'd1; h_c = 3'd4; end
      3'd2: begin shp = pk(0,0, 1,0, 0,1, 1,1); w_c = 3'd2; h_c = 3'd2; end
      3'd3: case (rot_q)
              2'd0: begin shp = pk(1,0, 0,1, 1,1, 2,1); w_c = 3'd3; h_c = 3'd2; end
              2'd1: begin shp = pk(0,0, 0,1, 0,2, 1,1); w_c = 3'd2; h_c = 3'd3; end
              2'd2: begin shp = pk(0,0, 1,0, 2,0, 1,1); w_c = 3'd3; h_c = 3'd2; end
              default: begin shp = pk(1,0, 1,1, 1,2, 0,1); w_c = 3'd2; h_c = 3'd3; end
            endcase
      3'd4: if (!rot_q[0]) begin shp = pk(1,0, 2,0, 0,1, 1,1); w_c = 3'd3; h_c = 3'd2; end
            else           begin shp = pk(0,0, 0,1, 1,1, 1,2); w_c = 3'd2; h_c = 3'd3; end
      3'd5: if (!rot_q[0]) begin shp = pk(0,0, 1,0, 1,1, 2,1); w_c = 3'd3; h_c = 3'd2; end
            else           begin shp = pk(1,0, 0,1, 0,2, 1,1); w_c = 3'd2; h_c = 3'd3; end
      3'd6: case (rot_q)
              2'd0: begin shp = pk(1,0, 1,1, 1,2, 0,2); w_c = 3'd2; h_c = 3'd3; end
              2'd1: begin shp = pk(0,0, 0,1, 1,1, 2,1); w_c = 3'd3; h_c = 3'd2; end
              2'd2: begin shp = pk(0,0, 0,1, 0,2, 1,0); w_c = 3'd2; h_c = 3'd3; end
              default: begin shp = pk(0,0, 1,0, 2,0, 2,1); w_c = 3'd3; h_c = 3'd2; end
            endcase
      3'd7: case (rot_q)
              2'd0: begin shp = pk(0,0, 0,1, 0,2, 1,2); w_c = 3'd2; h_c = 3'd3; end
              2'd1: begin shp = pk(0,1, 0,0, 1,0, 2,0); w_c = 3'd3; h_c = 3'd2; end
              2'd2: begin shp = pk(1,0, 1,1, 1,2, 0,0); w_c = 3'd2; h_c = 3'd3; end
              default: begin shp = pk(0,1, 1,1, 2,1, 2,0); w_c = 3'd3; h_c = 3'd2; end
            endcase
      default: ;
    endcase
  end

  always_comb begin
    cells_c = '1;
    if (piece_q != 3'd0) begin
      for (int k = 0; k < 4; k++) begin
        cells_c[k*IDX_W +: IDX_W] = IDX_W'((CW'(y_q) + CW'(shp[4*k+2 +: 2])) * CW'(BOARD_W)
                                           + CW'(x_q) + CW'(shp[4*k +: 2]));
      end
    end
    oob_c = (piece_q != 3'd0) &&
            (((XW+1)'(x_q) + (XW+1)'(w_c) > (XW+1)'(BOARD_W)) ||
             ((YW+1)'(y_q) + (YW+1)'(h_c) > (YW+1)'(BOARD_H)));
  end

  // pipe_q tracks issued reads; its top bit marks the cycle a return is valid.
  assign tap = pipe_q[RD_LAT-1];

  always_comb begin
    state_d     = state_q;
    piece_d     = piece_q;
    x_d         = x_q;
    y_d         = y_q;
    rot_d       = rot_q;
    req_ready_d = req_ready_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = rsp_valid_q;
    cells_d     = cells_q;
    w_d         = w_q;
    h_d         = h_q;
    oob_d       = oob_q;
    hit_d       = hit_q;
    iss_d       = iss_q;
    ret_d       = ret_q;
    pipe_d      = (pipe_q << 1) | RD_LAT'(rd_en_q);
    case (state_q)
      S_IDLE: if (req_valid) begin
        piece_d     = req_piece;
        x_d         = req_x;
        y_d         = req_y;
        rot_d       = req_rot;
        req_ready_d = 1'b0;
        state_d     = S_CALC;
      end
      S_CALC: begin
        cells_d = cells_c;
        w_d     = w_c;
        h_d     = h_c;
        oob_d   = oob_c;
        hit_d   = 1'b0;
        if (piece_q == 3'd0 || oob_c) begin
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = cells_c[IDX_W-1:0];
          iss_d     = 3'd1;
          ret_d     = 2'd0;
          state_d   = S_PROBE;
        end
      end
      S_PROBE: begin
        if (iss_q[2]) begin
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = cells_q[iss_q[1:0]*IDX_W +: IDX_W];
          iss_d     = iss_q + 3'd1;
        end
        if (tap) begin
          hit_d = hit_q | rd_data;
          ret_d = ret_q + 2'd1;
          if (ret_q == 2'd3) begin
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      default: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      piece_q     <= 3'd0;
      x_q         <= '0;
      y_q         <= '0;
      rot_q       <= 2'd0;
      req_ready_q <= 1'b1;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      cells_q     <= '0;
      w_q         <= 3'd0;
      h_q         <= 3'd0;
      oob_q       <= 1'b0;
      hit_q       <= 1'b0;
      iss_q       <= 3'd0;
      ret_q       <= 2'd0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      piece_q     <= piece_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rot_q       <= rot_d;
      req_ready_q <= req_ready_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      cells_q     <= cells_d;
      w_q         <= w_d;
      h_q         <= h_d;
      oob_q       <= oob_d;
      hit_q       <= hit_d;
      iss_q       <= iss_d;
      ret_q       <= ret_d;
      pipe_q      <= pipe_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_cells  = cells_q;
  assign rsp_width  = w_q;
  assign rsp_height = h_q;
  assign rsp_oob    = oob_q;
  assign rsp_hit    = hit_q;

endmodule

// File: tb/tb_piece_cell_gen.sv
// Directed bench: two instances (RD_LAT 1 and 2) share stimulus and a board model.
module tb_piece_cell_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, rsp_ready;
  logic [2:0]  req_piece;
  logic [3:0]  req_x;
  logic [4:0]  req_y;
  logic [1:0]  req_rot;

  logic        req_ready1, rd_en1, rd_data1, rsp_valid1, oob1, hit1;
  logic [7:0]  rd_addr1;
  logic [31:0] cells1;
  logic [2:0]  w1, h1;
  logic        req_ready2, rd_en2, rd_data2, rsp_valid2, oob2, hit2;
  logic [7:0]  rd_addr2;
  logic [31:0] cells2;
  logic [2:0]  w2, h2;

  logic [255:0] board;
  logic         inj;
  logic         q1, q2a, q2;

  int checks = 0;
  int errors = 0;

  piece_cell_gen #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_piece(req_piece), .req_x(req_x), .req_y(req_y), .req_rot(req_rot),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_cells(cells1),
    .rsp_width(w1), .rsp_height(h1), .rsp_oob(oob1), .rsp_hit(hit1));

  piece_cell_gen #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_piece(req_piece), .req_x(req_x), .req_y(req_y), .req_rot(req_rot),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_cells(cells2),
    .rsp_width(w2), .rsp_height(h2), .rsp_oob(oob2), .rsp_hit(hit2));

  always @(posedge clk) begin
    q1  <= rd_en1 ? board[rd_addr1] : 1'b0;
    q2a <= rd_en2 ? board[rd_addr2] : 1'b0;
    q2  <= q2a;
  end
  assign rd_data1 = q1 | inj;
  assign rd_data2 = q2 | inj;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy1"}, req_ready1, 1);  chk({tag, "_rdy2"}, req_ready2, 1);
    chk({tag, "_rden1"}, rd_en1, 0);     chk({tag, "_rden2"}, rd_en2, 0);
    chk({tag, "_addr1"}, rd_addr1, 0);   chk({tag, "_addr2"}, rd_addr2, 0);
    chk({tag, "_vld1"}, rsp_valid1, 0);  chk({tag, "_vld2"}, rsp_valid2, 0);
    chk({tag, "_cells1"}, cells1, 0);    chk({tag, "_cells2"}, cells2, 0);
    chk({tag, "_wh1"}, {w1, h1}, 0);     chk({tag, "_wh2"}, {w2, h2}, 0);
    chk({tag, "_flags1"}, {oob1, hit1}, 0);
    chk({tag, "_flags2"}, {oob2, hit2}, 0);
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] c, input logic [2:0] w,
                         input logic [2:0] h, input logic oob, input logic hit);
    chk({tag, "_cells1"}, cells1, c);  chk({tag, "_cells2"}, cells2, c);
    chk({tag, "_w1"}, w1, w);          chk({tag, "_w2"}, w2, w);
    chk({tag, "_h1"}, h1, h);          chk({tag, "_h2"}, h2, h);
    chk({tag, "_oob1"}, oob1, oob);    chk({tag, "_oob2"}, oob2, oob);
    chk({tag, "_hit1"}, hit1, hit);    chk({tag, "_hit2"}, hit2, hit);
  endtask

  // Called just after a falling edge; that cycle is cycle 0.
  task automatic do_req(input logic [2:0] p, input logic [3:0] x, input logic [4:0] y,
                        input logic [1:0] r, output int l1, output int l2,
                        output int n1, output int n2);
    chk("accept_rdy1", req_ready1, 1);
    chk("accept_rdy2", req_ready2, 1);
    l1 = 0; l2 = 0; n1 = 0; n2 = 0;
    req_piece = p; req_x = x; req_y = y; req_rot = r;
    req_valid = 1'b1;
    for (int c = 1; c <= 40 && (l1 == 0 || l2 == 0); c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rd_en1) n1++;
      if (rd_en2) n2++;
      if (rsp_valid1 && l1 == 0) l1 = c;
      if (rsp_valid2 && l2 == 0) l2 = c;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic chk_timing(input string tag, input int l1, input int l2, input int n1,
                            input int n2, input int el1, input int el2, input int en);
    chk({tag, "_lat1"}, l1, el1);  chk({tag, "_lat2"}, l2, el2);
    chk({tag, "_rds1"}, n1, en);   chk({tag, "_rds2"}, n2, en);
  endtask

  int l1, l2, n1, n2;

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; inj = 1'b0;
    req_piece = 3'd0; req_x = 4'd0; req_y = 5'd0; req_rot = 2'd0;
    board = '0;
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    do_req(3'd3, 4'd4, 5'd0, 2'd0, l1, l2, n1, n2);
    chk_timing("t_r0", l1, l2, n1, n2, 7, 8, 4);
    chk_rsp("t_r0", 32'h100F0E05, 3'd3, 3'd2, 1'b0, 1'b0);
    handshake();

    do_req(3'd1, 4'd7, 5'd3, 2'd0, l1, l2, n1, n2);
    chk_timing("i_oob", l1, l2, n1, n2, 2, 2, 0);
    chk_rsp("i_oob", 32'h28272625, 3'd4, 3'd1, 1'b1, 1'b0);
    handshake();

    do_req(3'd1, 4'd9, 5'd16, 2'd1, l1, l2, n1, n2);
    chk_timing("i_r1", l1, l2, n1, n2, 7, 8, 4);
    chk_rsp("i_r1", 32'hC7BDB3A9, 3'd1, 3'd4, 1'b0, 1'b0);
    handshake();

    board[191] = 1'b1;
    do_req(3'd2, 4'd0, 5'd18, 2'd0, l1, l2, n1, n2);
    chk_timing("o_hit", l1, l2, n1, n2, 7, 8, 4);
    chk_rsp("o_hit", 32'hBFBEB5B4, 3'd2, 3'd2, 1'b0, 1'b1);
    handshake();

    board = '0;
    board[192] = 1'b1;
    do_req(3'd2, 4'd0, 5'd18, 2'd0, l1, l2, n1, n2);
    chk_rsp("o_miss", 32'hBFBEB5B4, 3'd2, 3'd2, 1'b0, 1'b0);
    handshake();
    board = '0;

    do_req(3'd0, 4'd9, 5'd19, 2'd3, l1, l2, n1, n2);
    chk_timing("null", l1, l2, n1, n2, 2, 2, 0);
    chk_rsp("null", 32'hFFFFFFFF, 3'd0, 3'd0, 1'b0, 1'b0);
    handshake();

    do_req(3'd6, 4'd8, 5'd18, 2'd0, l1, l2, n1, n2);
    chk_timing("j_oob_y", l1, l2, n1, n2, 2, 2, 0);
    chk_rsp("j_oob_y", 32'hD0D1C7BD, 3'd2, 3'd3, 1'b1, 1'b0);
    handshake();

    do_req(3'd3, 4'd7, 5'd0, 2'd0, l1, l2, n1, n2);
    chk_timing("t_edge", l1, l2, n1, n2, 7, 8, 4);
    chk_rsp("t_edge", 32'h13121108, 3'd3, 3'd2, 1'b0, 1'b0);
    handshake();

    do_req(3'd4, 4'd2, 5'd5, 2'd0, l1, l2, n1, n2);
    chk_rsp("s_r0", 32'h3F3E3635, 3'd3, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_vld1", rsp_valid1, 1);     chk("stall_vld2", rsp_valid2, 1);
      chk("stall_rdy1", req_ready1, 0);     chk("stall_rdy2", req_ready2, 0);
      chk("stall_cells1", cells1, 32'h3F3E3635);
      chk("stall_cells2", cells2, 32'h3F3E3635);
      chk("stall_wh1", {w1, h1}, {3'd3, 3'd2});
    end
    handshake();

    do_req(3'd5, 4'd0, 5'd0, 2'd1, l1, l2, n1, n2);
    chk_timing("z_r1", l1, l2, n1, n2, 7, 8, 4);
    chk_rsp("z_r1", 32'h0B140A01, 3'd2, 3'd3, 1'b0, 1'b0);
    handshake();

    board = '1;
    req_piece = 3'd3; req_x = 4'd4; req_y = 5'd0; req_rot = 2'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("probe_rden1", rd_en1, 1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    inj = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    inj = 1'b0;
    board = '0;
    do_req(3'd7, 4'd0, 5'd0, 2'd1, l1, l2, n1, n2);
    chk_timing("l_r1", l1, l2, n1, n2, 7, 8, 4);
    chk_rsp("l_r1", 32'h0201000A, 3'd3, 3'd2, 1'b0, 1'b0);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
